// File: rtl/mem3_pkg.sv
// Shared types for the memory-3 response collector: access size, per-lane control, FSM state.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package mem3_pkg;

    typedef logic [1:0] msize_t;

    localparam msize_t MSIZE_B = 2'd0;
    localparam msize_t MSIZE_H = 2'd1;
    localparam msize_t MSIZE_W = 2'd2;

    // Per-lane control captured when the op group is issued.
    typedef struct packed {
        logic [1:0] addr_lo;
        msize_t     msize;
        logic       memsext;
        logic       load;
    } lane_ctl_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } m3_state_t;

    // Active load whose address cannot be served by a naturally aligned access.
    function automatic logic is_misaligned(lane_ctl_t c);
        return c.load && (((c.msize == MSIZE_H) && c.addr_lo[0]) ||
                          ((c.msize == MSIZE_W) && (c.addr_lo != 2'd0)));
    endfunction

endpackage

// File: rtl/mem3_resp_collect_load_align.sv
// Extracts and sign/zero-extends a byte, half or word from one raw 32-bit bus word.
// Latency: purely combinational.
// Backpressure: none.
module load_align
    import mem3_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  msize_t      msize,
    input  logic        sext,
    output logic [31:0] rd
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed byte/half and extend it to the full register width.
    always_comb begin
        byte_v = word[7:0];
        case (addr_lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        case (msize)
            MSIZE_B: rd = {{24{sext & byte_v[7]}}, byte_v};
            MSIZE_H: rd = {{16{sext & half_v[15]}}, half_v};
            default: rd = word;
        endcase
    end

endmodule

// File: rtl/mem3_resp_collect.sv
// Collects per-lane dbus load responses for one op group and releases one aligned bundle (optional MEM3_MISALIGN_CHECK_EN adds misalign port).
// Latency: 0 cycles from the last resp_ok to out_valid (live data bypasses the save registers).
// Backpressure: out_ready low parks a completed bundle in HOLD; stall holds the memory stage while waiting or blocked.
module mem3_resp_collect
    import mem3_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue,
    input  logic [N_LANES-1:0]         lane_load,
    input  logic [N_LANES*2-1:0]       addr_lo,
    input  logic [N_LANES*2-1:0]       msize,
    input  logic [N_LANES-1:0]         memsext,
    input  logic [N_LANES-1:0]         resp_ok,
    input  logic [N_LANES*DATA_W-1:0]  resp_data,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [N_LANES*DATA_W-1:0]  out_rd,
    output logic                       stall
`ifdef MEM3_MISALIGN_CHECK_EN
    ,
    output logic [N_LANES-1:0]         misalign
`endif
);

    m3_state_t                         state_q, state_d;
    lane_ctl_t [N_LANES-1:0]           ctl_q, ctl_d;
    logic [N_LANES-1:0]                saved_q, saved_d;
    logic [N_LANES-1:0][DATA_W-1:0]    save_data_q, save_data_d;
    logic [N_LANES-1:0][1:0]           drop_q, drop_d;
    logic [N_LANES-1:0][2:0]           drop_sum;

    logic [N_LANES-1:0]                active, live, done, mis;
    logic                              all_done;
    logic [N_LANES-1:0][DATA_W-1:0]    src_data, aligned;

`ifdef MEM3_MISALIGN_CHECK_EN
    logic [N_LANES-1:0]                misalign_q, misalign_d;
    assign mis      = misalign_q;
    assign misalign = misalign_q;
`else
    assign mis = '0;
`endif

    // Per-lane completion: a response only belongs to this group once stale ones are drained.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            active[i] = ctl_q[i].load;
            live[i]   = resp_ok[i] && (drop_q[i] == 2'd0);
            done[i]   = !active[i] || saved_q[i] || live[i] || mis[i];
        end
        all_done = &done;
    end

    // Group FSM: capture control at issue, save early responses, park blocked bundles.
    always_comb begin
        state_d     = state_q;
        ctl_d       = ctl_q;
        saved_d     = saved_q;
        save_data_d = save_data_q;
        out_valid   = 1'b0;
`ifdef MEM3_MISALIGN_CHECK_EN
        misalign_d  = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (issue) begin
                    for (int i = 0; i < N_LANES; i++) begin
                        ctl_d[i].addr_lo = addr_lo[2*i +: 2];
                        ctl_d[i].msize   = msize[2*i +: 2];
                        ctl_d[i].memsext = memsext[i];
                        ctl_d[i].load    = lane_load[i];
`ifdef MEM3_MISALIGN_CHECK_EN
                        misalign_d[i]    = is_misaligned(ctl_d[i]);
`endif
                    end
                    if (lane_load != '0) state_d = WAIT;
                    else                 out_valid = 1'b1;
                end
            end
            WAIT: begin
                if (all_done) begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = IDLE;
                        saved_d = '0;
                    end else begin
                        state_d = HOLD;
                        for (int i = 0; i < N_LANES; i++) begin
                            if (live[i] && !saved_q[i]) save_data_d[i] = resp_data[i*DATA_W +: DATA_W];
                        end
                    end
                end else begin
                    for (int i = 0; i < N_LANES; i++) begin
                        if (live[i] && !saved_q[i]) begin
                            save_data_d[i] = resp_data[i*DATA_W +: DATA_W];
                            saved_d[i]     = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    saved_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // A squash overrides everything, including a bundle completing this cycle.
        if (flush) begin
            state_d   = IDLE;
            saved_d   = '0;
            out_valid = 1'b0;
        end
    end

    // Stale-response accounting: each lane still owed a response at flush must swallow one later.
    always_comb begin
        for (int i = 0; i < N_LANES; i++) begin
            drop_sum[i] = {1'b0, drop_q[i]}
                        - {2'b00, (resp_ok[i] && (drop_q[i] != 2'd0))}
                        + {2'b00, (flush && (state_q == WAIT) && active[i] && !saved_q[i]
                                   && !mis[i] && !live[i])};
            drop_d[i]   = (drop_sum[i] > 3'd3) ? 2'd3 : drop_sum[i][1:0];
        end
    end

    // Result path: live bypass in WAIT, saved data otherwise; idle/inactive/misaligned lanes read 0.
    always_comb begin
        out_rd = '0;
        for (int i = 0; i < N_LANES; i++) begin
            src_data[i] = (state_q == WAIT && live[i] && !saved_q[i])
                        ? resp_data[i*DATA_W +: DATA_W] : save_data_q[i];
            if (out_valid && (state_q != IDLE) && active[i] && !mis[i])
                out_rd[i*DATA_W +: DATA_W] = aligned[i];
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        load_align u_align (
            .word    (src_data[g]),
            .addr_lo (ctl_q[g].addr_lo),
            .msize   (ctl_q[g].msize),
            .sext    (ctl_q[g].memsext),
            .rd      (aligned[g])
        );
    end

    assign stall = ((state_q == WAIT) && !all_done)
                || ((state_q == HOLD) && !out_ready)
                || (out_valid && !out_ready);

    // State and lane registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ctl_q       <= '0;
            saved_q     <= '0;
            save_data_q <= '0;
            drop_q      <= '0;
`ifdef MEM3_MISALIGN_CHECK_EN
            misalign_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            saved_q     <= saved_d;
            save_data_q <= save_data_d;
            drop_q      <= drop_d;
`ifdef MEM3_MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

endmodule
